// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the 5-stage MIPS pipeline:
//   - ALU control encodings driven from the decoder into EX
//   - R-type funct code for MUL
//   - state type for the multi-cycle multiply controller
//   - helper for sizing iteration counters
// ---------------------------------------------------------------------------
package cpu_pkg;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_MUL = 4'b1111;

   localparam logic [5:0] FUNCT_MUL = 6'b011000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } mul_state_t;

   // Counter width for an iteration index 0..w-1 (never narrower than 1 bit).
   function automatic int cnt_width(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/mul_shift_add_dp.sv
// ---------------------------------------------------------------------------
// mul_shift_add_dp
// Shift-add multiplier datapath, one multiplier bit per step. Holds the
// multiplicand, remaining multiplier bits, accumulator and iteration count.
// Sequencing decisions live in mul_sequencer; this block only obeys strobes.
//
// Ports:
//   clk, reset        pipeline clock, synchronous active-high reset
//   clear             zero all registers (abort path)
//   load              capture operands, zero acc and count
//   step              perform one shift-add iteration
//   load_mcand        multiplicand to capture on load
//   load_mplier       multiplier to capture on load
//   acc_next          accumulator value after the current step
//   mplier_zero_next  remaining multiplier bits are all zero after this step
//   last_iter         current step is iteration WIDTH-1
// ---------------------------------------------------------------------------
module mul_shift_add_dp
   import cpu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             load,
   input  logic             step,
   input  logic [WIDTH-1:0] load_mcand,
   input  logic [WIDTH-1:0] load_mplier,
   output logic [WIDTH-1:0] acc_next,
   output logic             mplier_zero_next,
   output logic             last_iter
);

   localparam int CNT_W = cnt_width(WIDTH);

   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Sum wraps mod 2^WIDTH; only the low word of the product is kept.
   assign acc_next         = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
   assign mplier_zero_next = ((mplier_q >> 1) == '0);
   assign last_iter        = (cnt_q == CNT_W'(WIDTH - 1));

   always_comb begin
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      if (clear) begin
         mcand_d  = '0;
         mplier_d = '0;
         acc_d    = '0;
         cnt_d    = '0;
      end else if (load) begin
         mcand_d  = load_mcand;
         mplier_d = load_mplier;
         acc_d    = '0;
         cnt_d    = '0;
      end else if (step) begin
         acc_d    = acc_next;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
      end else begin
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: rtl/mul_sequencer.sv
// ---------------------------------------------------------------------------
// mul_sequencer
// EX-stage controller for the multi-cycle MUL instruction. Starts the
// shift-add datapath, freezes the front of the pipeline while it iterates,
// and hands the low product word to EX/MEM with a one-cycle done pulse.
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   IDLE  | no multiply in flight; a valid, unsquashed MUL starts one
//   RUN   | one multiplier bit per cycle; pipeline stalled
//   DONE  | mulResult valid, EX/MEM captures it this edge; stall released
//
// Ports:
//   clk, reset  pipeline clock, synchronous active-high reset
//   startE      valid MUL in EX
//   flushE      EX instruction squashed
//   srcAE       multiplicand
//   srcBE       multiplier
//   stallMul    freeze PC, IF/ID, ID/EX; bubble EX/MEM
//   mulDone     one-cycle pulse, mulResult valid
//   mulBusy     controller not in IDLE
//   mulResult   low WIDTH bits of the product, held until the next DONE
// ---------------------------------------------------------------------------
module mul_sequencer
   import cpu_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter bit EARLY_TERM = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             startE,
   input  logic             flushE,
   input  logic [WIDTH-1:0] srcAE,
   input  logic [WIDTH-1:0] srcBE,
   output logic             stallMul,
   output logic             mulDone,
   output logic             mulBusy,
   output logic [WIDTH-1:0] mulResult
);

   mul_state_t       state_q, state_d;
   logic [WIDTH-1:0] result_q, result_d;

   logic             dp_clear;
   logic             dp_load;
   logic             dp_step;
   logic [WIDTH-1:0] acc_next;
   logic             mplier_zero_next;
   logic             last_iter;

   mul_shift_add_dp #(
      .WIDTH (WIDTH)
   ) u_dp (
      .clk              (clk),
      .reset            (reset),
      .clear            (dp_clear),
      .load             (dp_load),
      .step             (dp_step),
      .load_mcand       (srcAE),
      .load_mplier      (srcBE),
      .acc_next         (acc_next),
      .mplier_zero_next (mplier_zero_next),
      .last_iter        (last_iter)
   );

   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      dp_clear = 1'b0;
      dp_load  = 1'b0;
      dp_step  = 1'b0;
      stallMul = 1'b0;
      mulDone  = 1'b0;
      case (state_q)
         IDLE: begin
            if (startE && !flushE) begin
               stallMul = 1'b1;
               dp_load  = 1'b1;
               state_d  = RUN;
            end
         end
         RUN: begin
            // Stall stays up in the flush cycle; it drops once back in IDLE.
            stallMul = 1'b1;
            if (flushE) begin
               dp_clear = 1'b1;
               state_d  = IDLE;
            end else begin
               dp_step = 1'b1;
               if (last_iter || (EARLY_TERM && mplier_zero_next)) begin
                  // Capture the final sum now so mulResult is a plain flop in DONE.
                  result_d = acc_next;
                  state_d  = DONE;
               end
            end
         end
         DONE: begin
            // startE here belongs to the MUL that is leaving; ignore it.
            mulDone = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign mulBusy   = (state_q != IDLE);
   assign mulResult = result_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
      end
   end

endmodule

// File: tb/tb_mul_sequencer.sv
module tb_mul_sequencer;

   localparam int W = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         reset;
   logic         flush;
   logic         start_et, start_nt;
   logic [W-1:0] src_a, src_b;
   logic         stall_et, done_et, busy_et;
   logic         stall_nt, done_nt, busy_nt;
   logic [W-1:0] res_et, res_nt;

   mul_sequencer #(.WIDTH(W), .EARLY_TERM(1'b1)) dut_et (
      .clk       (clk),
      .reset     (reset),
      .startE    (start_et),
      .flushE    (flush),
      .srcAE     (src_a),
      .srcBE     (src_b),
      .stallMul  (stall_et),
      .mulDone   (done_et),
      .mulBusy   (busy_et),
      .mulResult (res_et)
   );

   mul_sequencer #(.WIDTH(W), .EARLY_TERM(1'b0)) dut_nt (
      .clk       (clk),
      .reset     (reset),
      .startE    (start_nt),
      .flushE    (flush),
      .srcAE     (src_a),
      .srcBE     (src_b),
      .stallMul  (stall_nt),
      .mulDone   (done_nt),
      .mulBusy   (busy_nt),
      .mulResult (res_nt)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errs   = 0;
   int checks = 0;

   typedef struct {
      logic [W-1:0] res;
      int           t;
   } sb_t;

   sb_t q_et[$];
   sb_t q_nt[$];

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      bit           nt;
      logic [W-1:0] res;
      int           lat;
   } vec_t;

   vec_t vecs[9];

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s cycle %0d: got %0b expected %0b", name, cyc, act, exp);
      end
   endtask

   task automatic chkw(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // Scoreboards: every done pulse must match the oldest outstanding op.
   always @(negedge clk) begin
      if (done_et === 1'b1) begin
         if (q_et.size() == 0) begin
            chk1("et unexpected done", done_et, 1'b0);
         end else begin
            sb_t e;
            e = q_et.pop_front();
            chkw("et result", res_et, e.res);
            chkw("et done cycle", cyc, e.t);
         end
      end
   end

   always @(negedge clk) begin
      if (done_nt === 1'b1) begin
         if (q_nt.size() == 0) begin
            chk1("nt unexpected done", done_nt, 1'b0);
         end else begin
            sb_t e;
            e = q_nt.pop_front();
            chkw("nt result", res_nt, e.res);
            chkw("nt done cycle", cyc, e.t);
         end
      end
   end

   // Called at a negedge; that cycle is cycle 0 of the op. Returns at the
   // negedge of the IDLE cycle following DONE. With keep=1 startE stays high
   // through DONE (and must be ignored there).
   task automatic mul_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit nt,
                         input bit keep, input logic [W-1:0] exp_res, input int exp_lat);
      sb_t e;
      src_a = a;
      src_b = b;
      if (nt) start_nt = 1'b1;
      else    start_et = 1'b1;
      e.res = exp_res;
      e.t   = cyc + exp_lat;
      if (nt) q_nt.push_back(e);
      else    q_et.push_back(e);
      for (int i = 0; i <= exp_lat; i++) begin
         #1;
         chk1("stall", nt ? stall_nt : stall_et, (i < exp_lat));
         chk1("busy",  nt ? busy_nt  : busy_et,  (i > 0));
         chk1("done",  nt ? done_nt  : done_et,  (i == exp_lat));
         if (i == exp_lat && !keep) begin
            start_et = 1'b0;
            start_nt = 1'b0;
         end
         @(negedge clk);
      end
      if (!keep) begin
         #1;
         chk1("idle busy",  nt ? busy_nt  : busy_et,  1'b0);
         chk1("idle stall", nt ? stall_nt : stall_et, 1'b0);
         chkw("held result", nt ? res_nt : res_et, exp_res);
      end
   endtask

   logic [W-1:0] last_et;

   initial begin
      vecs[0] = '{32'd3,         32'd5,         1'b0, 32'd15,        4};
      vecs[1] = '{32'd7,         32'd0,         1'b0, 32'd0,         2};
      vecs[2] = '{32'h00010000,  32'h00010000,  1'b0, 32'd0,         18};
      vecs[3] = '{32'hFFFFFFFF,  32'hFFFFFFFF,  1'b1, 32'h00000001,  33};
      vecs[4] = '{32'hFFFFFFFF,  32'hFFFFFFFF,  1'b0, 32'h00000001,  33};
      vecs[5] = '{32'hDEADBEEF,  32'h80000000,  1'b1, 32'h80000000,  33};
      vecs[6] = '{32'h12345678,  32'h00000001,  1'b0, 32'h12345678,  2};
      vecs[7] = '{32'hFFFFFFFD,  32'd5,         1'b0, 32'hFFFFFFF1,  4};
      vecs[8] = '{32'd123456,    32'd789,       1'b0, 32'd97406784,  11};

      reset    = 1'b1;
      flush    = 1'b0;
      start_et = 1'b0;
      start_nt = 1'b0;
      src_a    = '0;
      src_b    = '0;
      last_et  = '0;

      repeat (3) @(negedge clk);
      #1;
      chk1("reset stall", stall_et, 1'b0);
      chk1("reset done",  done_et,  1'b0);
      chk1("reset busy",  busy_et,  1'b0);
      chkw("reset result", res_et, '0);
      chk1("reset nt busy", busy_nt, 1'b0);
      chkw("reset nt result", res_nt, '0);
      reset = 1'b0;
      @(negedge clk);

      // Table-driven single operations.
      for (int v = 0; v < 9; v++) begin
         mul_op(vecs[v].a, vecs[v].b, vecs[v].nt, 1'b0, vecs[v].res, vecs[v].lat);
         if (!vecs[v].nt) last_et = vecs[v].res;
         @(negedge clk);
      end

      // Flush in RUN at cycle 3: abort, no done, result untouched.
      src_a    = 32'd9;
      src_b    = 32'h80;
      start_et = 1'b1;
      #1;
      chk1("flush c0 stall", stall_et, 1'b1);
      @(negedge clk); #1;
      chk1("flush c1 busy", busy_et, 1'b1);
      @(negedge clk); #1;
      chk1("flush c2 stall", stall_et, 1'b1);
      @(negedge clk);
      flush    = 1'b1;
      start_et = 1'b0;
      #1;
      chk1("flush c3 stall", stall_et, 1'b1);
      @(negedge clk);
      flush = 1'b0;
      #1;
      chk1("flush c4 stall", stall_et, 1'b0);
      chk1("flush c4 busy",  busy_et,  1'b0);
      chk1("flush c4 done",  done_et,  1'b0);
      chkw("flush c4 result", res_et, last_et);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk); #1;
         chk1("flush no done", done_et, 1'b0);
      end
      chkw("flush result kept", res_et, last_et);
      @(negedge clk);

      // Reset in RUN at cycle 3: everything back to zero.
      src_a    = 32'd9;
      src_b    = 32'h80;
      start_et = 1'b1;
      @(negedge clk); #1;
      chk1("rst c1 busy", busy_et, 1'b1);
      @(negedge clk);
      @(negedge clk);
      reset    = 1'b1;
      start_et = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk1("rst c4 stall", stall_et, 1'b0);
      chk1("rst c4 busy",  busy_et,  1'b0);
      chk1("rst c4 done",  done_et,  1'b0);
      chkw("rst c4 result", res_et, '0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk); #1;
         chk1("rst no done", done_et, 1'b0);
      end
      @(negedge clk);

      // Back-to-back: startE held through DONE, second op starts in IDLE.
      mul_op(32'd6, 32'd7, 1'b0, 1'b1, 32'd42, 4);
      mul_op(32'd2, 32'd3, 1'b0, 1'b0, 32'd6, 3);
      @(negedge clk);

      // startE with flushE in IDLE: no start.
      src_a    = 32'd5;
      src_b    = 32'd5;
      start_et = 1'b1;
      flush    = 1'b1;
      #1;
      chk1("sqz stall", stall_et, 1'b0);
      @(negedge clk);
      start_et = 1'b0;
      flush    = 1'b0;
      for (int i = 0; i < 6; i++) begin
         #1;
         chk1("sqz busy", busy_et, 1'b0);
         chk1("sqz done", done_et, 1'b0);
         @(negedge clk);
      end
      chkw("sqz result kept", res_et, 32'd6);

      // Still functional afterwards, non-early-terminating instance.
      mul_op(32'd1000, 32'd1000, 1'b1, 1'b0, 32'd1000000, 33);

      repeat (3) @(negedge clk);
      chkw("et queue drained", q_et.size(), '0);
      chkw("nt queue drained", q_nt.size(), '0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/mul_sequencer.md
Name: mul_sequencer

Overview:
- Multi-cycle controller for the MUL R-type operation (ALU control 4'b1111, funct 6'b011000) in the EX stage of the 5-stage MIPS pipeline.
- Sequences an iterative shift-add multiplier, one multiplier bit per cycle.
- Holds the pipeline frozen through a stall output until the product is ready.
- Presents the low word of the product for one cycle as the EX result.

Parameters:
- WIDTH, 32, operand and result width in bits.
- EARLY_TERM, 1, when 1 the sequence ends as soon as the remaining multiplier bits are all zero; when 0 it always runs WIDTH iterations.

Ports:
- clk  input  1  pipeline clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- startE  input  1  the instruction in EX is a valid MUL (ALUControlE==4'b1111, not bubbled).
- flushE  input  1  the EX instruction is being squashed (branch taken / redirect).
- srcAE  input  WIDTH  multiplicand (forwarded rs value).
- srcBE  input  WIDTH  multiplier (forwarded rt value).
- stallMul  output  1  freeze PC, IF/ID, ID/EX; bubble EX/MEM.
- mulDone  output  1  one-cycle pulse: mulResult is valid and EX/MEM captures it this edge.
- mulBusy  output  1  state != IDLE.
- mulResult  output  WIDTH  low WIDTH bits of srcAE*srcBE. Signed and unsigned products are identical in the low word.

Behaviour:
- Reset: state=IDLE; stallMul=0, mulDone=0, mulBusy=0, mulResult=0; internal accumulator, operands and counter cleared. Reset wins over every other input, including mid-operation.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - stallMul = startE & ~flushE (combinational, same cycle).
  - On that condition: latch mcand=srcAE, mplier=srcBE, acc=0, cnt=0; next state RUN.
  - Otherwise stay in IDLE.
- RUN (per cycle):
  - if mplier[0], acc <= acc + mcand (mod 2^WIDTH);
  - mcand <= mcand<<1; mplier <= mplier>>1; cnt <= cnt+1.
  - stallMul=1, mulBusy=1.
  - Next state DONE if cnt==WIDTH-1, or (EARLY_TERM && (mplier>>1)==0). Otherwise stay in RUN.
- DONE:
  - stallMul=0, mulDone=1, mulResult=acc (registered).
  - The MUL leaves EX at this edge. startE is ignored in DONE.
  - Next state IDLE unconditionally.
- Latency (start cycle = 0):
  - mulDone at cycle k+2, where k is the index of the highest set bit of srcBE (k=0 when srcBE==0), with EARLY_TERM=1.
  - mulDone always at cycle WIDTH+1 with EARLY_TERM=0.
  - stallMul is high on cycles 0..mulDone-1.
- Back-to-back MULs: the second startE is taken in the IDLE cycle after DONE. There is no dead stall cycle beyond that.
- flushE:
  - In IDLE: suppresses the start.
  - In RUN: abort to IDLE next cycle. No mulDone, stallMul=0 from the next cycle, mulResult unchanged.
  - In DONE: no effect; the pipeline handles the squash.
- mulResult holds its last value until the next DONE. Overflow beyond WIDTH bits is discarded.
- cnt width is clog2(WIDTH).

Decomposition:
- Shared package (cpu_pkg):
  - ALU control constants: ALU_AND=4'b0000, ALU_OR=4'b0001, ALU_ADD=4'b0010, ALU_SUB=4'b0110, ALU_MUL=4'b1111.
  - FUNCT_MUL=6'b011000.
  - mul_state_t enum {IDLE, RUN, DONE}.
- Sub-module mul_shift_add_dp:
  - holds the mcand/mplier/acc/cnt registers;
  - controlled by load/step/clear strobes from the FSM in mul_sequencer;
  - reports mplier_zero_next and last_iter back to the FSM.

Test Plan:
- 3*5, EARLY_TERM=1 -> stallMul high cycles 0-3, mulDone at cycle 4, mulResult=32'd15, mulBusy low at cycle 5.
- 7*0 -> mulDone at cycle 2, mulResult=0. 32'h00010000*32'h00010000 -> mulDone at cycle 18, mulResult=0 (overflow discarded).
- 32'hFFFFFFFF*32'hFFFFFFFF with EARLY_TERM=0 -> stallMul high cycles 0-32, mulDone at cycle 33, mulResult=32'h00000001. Repeat with EARLY_TERM=1 -> same timing (k=31).
- Start 9*32'h80 then flushE at cycle 3 -> IDLE at cycle 4, stallMul=0 at cycle 4, no mulDone, mulResult keeps its prior value. Repeat with reset at cycle 3 instead -> all outputs 0 at cycle 4.
- Back-to-back 6*7 then 2*3 (startE held for the new instr) -> mulDone with 42, then IDLE start on the next cycle, mulDone with 6 three cycles later. startE asserted in the DONE cycle is ignored.
- startE together with flushE in IDLE -> stallMul=0 that cycle, state stays IDLE, no mulDone.
